lamp_sequence_monitor: RTL
==========================

# lamp_sequence_monitor

Passive checker on the 3-bit lamp bus driven by the cyclic lamp controller. It samples the bus every clock, decodes the current phase, and confirms that the phase order is GREEN -> YELLOW -> RED -> GREEN. It also checks that each phase holds for an allowed number of cycles and counts completed cycles. Any violation raises a sticky fault with a cause code, for use by a supervisor or a testbench scoreboard.

## Interface
- MIN_DWELL, 1, minimum consecutive samples a phase must hold before a legal transition (>=1)
- MAX_DWELL, 1, maximum consecutive samples a phase may hold (>= MIN_DWELL)
- CNT_W, 8, width of cycle_count
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to reset state on the next rising edge
- light  in  3  lamp code, MSB first: RED=3'b100, YELLOW=3'b101, GREEN=3'b110; all other values illegal
- fault_clr  in  1  synchronous pulse; clears fault and returns to SYNC
- phase  out  2  decoded phase: 0 none, 1 GREEN, 2 YELLOW, 3 RED
- in_sync  out  1  high while state is TRACK
- fault  out  1  sticky violation flag
- fault_code  out  2  0 none, 1 ILLEGAL (bad code), 2 ORDER (wrong successor), 3 DWELL (short or stuck)
- cycle_count  out  CNT_W  number of legal RED->GREEN transitions; wraps modulo 2^CNT_W

## Operation
- State machine: SYNC, TRACK, FAULT. Reset enters SYNC.
- Internal dwell counter is wide enough to hold MAX_DWELL+1. It saturates and never wraps.
- In SYNC:
  - Legal code -> TRACK; phase = decoded code; dwell = 1.
  - First phase after sync is exempt from the MIN_DWELL check. It is still subject to MAX_DWELL.
  - Illegal code -> stay in SYNC; no fault.
- In TRACK, with each sample `s`:
  - `s` illegal -> FAULT, code 1.
  - `s` equals the current phase code -> dwell+1. If the new dwell exceeds MAX_DWELL -> FAULT, code 3.
  - `s` is the legal successor (G->Y, Y->R, R->G):
    - If dwell < MIN_DWELL and the phase is not exempt -> FAULT, code 3.
    - Otherwise phase = successor and dwell = 1. On R->G, cycle_count+1.
  - Any other legal code (for example G->R or Y->G) -> FAULT, code 2.
- Priority within one sample: ILLEGAL > ORDER > DWELL.
- In FAULT:
  - fault=1, fault_code, phase and cycle_count hold their values. Further bus activity is ignored.
  - Exit is only by reset or fault_clr.
- fault_clr from any state:
  - Next state is SYNC; fault=0, fault_code=0, phase=0.
  - cycle_count is retained.
  - The bus sample in that cycle is ignored.
- fault_clr and a violation in the same cycle: clear wins.
- reset overrides fault_clr. reset asserted mid-operation aborts tracking with no partial update.

## Timing
- All outputs are registered. The bus is sampled at a rising edge, and phase/in_sync/fault/fault_code/cycle_count reflect that sample immediately after the same edge (1-cycle latency from bus change to output).
- Reset values: phase=0, in_sync=0, fault=0, fault_code=0, cycle_count=0, dwell=0, state=SYNC.
- fault rises on the edge that samples the violating code. It stays high until reset or fault_clr is sampled high.
- cycle_count updates on the edge that samples the GREEN following RED.
- No combinational path from inputs to outputs.

## Test plan
- Defaults; reset 2 cycles, then drive G,Y,R repeated 4 times, then G -> in_sync=1 from the first sample, fault=0 throughout, cycle_count=4, phase tracks 1,2,3 with 1-cycle latency.
- Defaults; drive G,Y,R,G,3'b111 -> fault=1, code 1 on the 3'b111 sample. Then drive legal codes for 3 cycles -> phase frozen at 1, cycle_count=1.
- Defaults; drive G,R -> fault=1, code 2, phase stays 1. Then pulse fault_clr and drive Y,R,G -> re-sync on Y, cycle_count=1, fault=0.
- MIN_DWELL=2, MAX_DWELL=3; drive G,G,Y,Y,Y,R -> first R sample is accepted. Then G on the next cycle -> fault, code 3 (short dwell). Repeat from clear with Y held 4 samples -> fault, code 3 on the 4th Y.
- Defaults; drive 3'b000 for 5 cycles after reset -> remains SYNC, in_sync=0, fault=0. Then G -> in_sync=1, phase=1.
- Mid-operation and simultaneous events:
  - Assert reset during TRACK with cycle_count=2 -> all outputs return to reset values on the next edge.
  - fault_clr and an illegal code in the same cycle -> fault stays 0, state SYNC.

Source files
------------

// File: rtl/lamp_sequence_monitor_if.sv
// Lamp bus as seen by the sequence monitor: the sampled lamp code, the clear
// pulse, and the monitor's registered status outputs.
interface lamp_sequence_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light;
    logic             fault_clr;
    logic [1:0]       phase;
    logic             in_sync;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output light, fault_clr,
        input  phase, in_sync, fault, fault_code, cycle_count
    );

    modport slave (
        input  light, fault_clr,
        output phase, in_sync, fault, fault_code, cycle_count
    );
endinterface

// File: rtl/lamp_sequence_monitor.sv
// Passive checker for the GREEN -> YELLOW -> RED lamp cycle: enforces phase
// order and dwell limits, counts completed cycles, latches a sticky fault code.
module lamp_sequence_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input logic                    clk,
    input logic                    reset,
    lamp_sequence_monitor_if.slave bus
);
    typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_FAULT} state_t;
    typedef enum logic [1:0] {PH_NONE, PH_GREEN, PH_YELLOW, PH_RED} phase_t;
    typedef enum logic [1:0] {FC_NONE, FC_ILLEGAL, FC_ORDER, FC_DWELL} fcode_t;

    // Dwell must be able to represent MAX_DWELL+1 so a stuck phase is visible.
    localparam int DW_W = $clog2(MAX_DWELL + 2);
    localparam logic [DW_W-1:0] DW_MINV = DW_W'(MIN_DWELL);
    localparam logic [DW_W-1:0] DW_MAXV = DW_W'(MAX_DWELL);
    localparam logic [DW_W-1:0] DW_SAT  = DW_W'(MAX_DWELL + 1);

    function automatic phase_t decode(input logic [2:0] code);
        case (code)
            3'b110:  decode = PH_GREEN;
            3'b101:  decode = PH_YELLOW;
            3'b100:  decode = PH_RED;
            default: decode = PH_NONE;
        endcase
    endfunction

    function automatic phase_t successor(input phase_t p);
        case (p)
            PH_GREEN:  successor = PH_YELLOW;
            PH_YELLOW: successor = PH_RED;
            PH_RED:    successor = PH_GREEN;
            default:   successor = PH_NONE;
        endcase
    endfunction

    state_t           state;
    phase_t           phase;
    fcode_t           fault_code;
    logic             in_sync;
    logic             fault;
    logic             exempt;
    logic [DW_W-1:0]  dwell;
    logic [CNT_W-1:0] cycle_count;

    phase_t          s_ph;
    fcode_t          viol;
    logic            advance;
    logic [DW_W-1:0] dwell_inc;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        s_ph      = decode(bus.light);
        viol      = FC_NONE;
        advance   = 1'b0;
        dwell_inc = (dwell == DW_SAT) ? dwell : dwell + 1'b1;
        if (state == ST_TRACK) begin
            if (s_ph == PH_NONE) begin
                viol = FC_ILLEGAL;
            end else if (s_ph == phase) begin
                if (dwell_inc > DW_MAXV) viol = FC_DWELL;
            end else if (s_ph == successor(phase)) begin
                if (dwell < DW_MINV && !exempt) viol = FC_DWELL;
                else                            advance = 1'b1;
            end else begin
                viol = FC_ORDER;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_SYNC;
            phase       <= PH_NONE;
            fault_code  <= FC_NONE;
            in_sync     <= 1'b0;
            fault       <= 1'b0;
            exempt      <= 1'b0;
            dwell       <= '0;
            cycle_count <= '0;
        end else if (bus.fault_clr) begin
            state      <= ST_SYNC;
            phase      <= PH_NONE;
            fault_code <= FC_NONE;
            in_sync    <= 1'b0;
            fault      <= 1'b0;
            exempt     <= 1'b0;
            dwell      <= '0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (s_ph != PH_NONE) begin
                        state   <= ST_TRACK;
                        in_sync <= 1'b1;
                        phase   <= s_ph;
                        dwell   <= DW_W'(1);
                        exempt  <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (viol != FC_NONE) begin
                        state      <= ST_FAULT;
                        in_sync    <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= viol;
                    end else if (advance) begin
                        phase  <= s_ph;
                        dwell  <= DW_W'(1);
                        exempt <= 1'b0;
                        if (phase == PH_RED) cycle_count <= cycle_count + 1'b1;
                    end else begin
                        dwell <= dwell_inc;
                    end
                end
                ST_FAULT: ;
                default:  state <= ST_SYNC;
            endcase
        end
    end

    assign bus.phase       = phase;
    assign bus.in_sync     = in_sync;
    assign bus.fault       = fault;
    assign bus.fault_code  = fault_code;
    assign bus.cycle_count = cycle_count;
endmodule
